fetch_stage: RTL

Instruction-fetch stage of the comp101 CPU. It owns the program counter, issues one instruction-memory read at a time, and presents each fetched instruction with its PC to decode over a valid/ready handshake. It consumes the next-PC value from the PC-select mux: a redirect carries the mux output. It also exports `out_pc_plus4`, which feeds that mux's sequential input.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/mux2x1.sv | 14 +
 rtl/fetch_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// comp101 shared CPU definitions.
// Fetch FSM states and PC constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_STEP = 4;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/mux2x1.sv
// comp101 generic two-input mux.
// y = sel ? d1 : d0.
module mux2x1 #(
  parameter int n = 32
) (
  input  logic [n-1:0] d0,
  input  logic [n-1:0] d1,
  input  logic         sel,
  output logic [n-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/fetch_stage.sv
// comp101 instruction-fetch stage.
// Owns the PC, one imem read in flight, valid/ready to decode.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int          N        = 32,
  parameter logic [N-1:0] RESET_PC = N'(RESET_PC_DEFAULT)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [N-1:0] imem_req_addr,
  input  logic         imem_rsp_valid,
  input  logic [N-1:0] imem_rsp_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_pc,
  output logic [N-1:0] out_instr,
  output logic [N-1:0] out_pc_plus4
);

  fetch_state_t state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic         drop_q, drop_d;
  logic [N-1:0] opc_q, opc_d;
  logic [N-1:0] oins_q, oins_d;
  logic [N-1:0] pc_seq;
  logic [N-1:0] pc_next;

  assign pc_seq = pc_q + N'(PC_STEP);

  mux2x1 #(.n(N)) u_pc_mux (
    .d0  (pc_seq),
    .d1  (redirect_pc),
    .sel (redirect_valid),
    .y   (pc_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      opc_q   <= '0;
      oins_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      opc_q   <= opc_d;
      oins_q  <= oins_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    opc_d   = opc_q;
    oins_d  = oins_q;
    if (redirect_valid) pc_d = pc_next;
    case (state_q)
      REQ: begin
        if (imem_req_ready) begin
          state_d = WAIT;
          if (redirect_valid) drop_d = 1'b1;
        end
      end
      WAIT: begin
        // A redirect coinciding with the response retires it as dropped.
        if (imem_rsp_valid) begin
          drop_d  = 1'b0;
          state_d = REQ;
          if (!redirect_valid && !drop_q) begin
            state_d = HOLD;
            opc_d   = pc_q;
            oins_d  = imem_rsp_data;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          state_d = REQ;
        end else if (out_ready) begin
          state_d = REQ;
          pc_d    = pc_next;
        end
      end
      default: state_d = REQ;
    endcase
  end

  assign imem_req_valid = rst_n && (state_q == REQ);
  assign imem_req_addr  = pc_q;
  assign out_valid      = (state_q == HOLD);
  assign out_pc         = opc_q;
  assign out_instr      = oins_q;
  assign out_pc_plus4   = opc_q + N'(PC_STEP);

  rsp_only_in_wait: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> state_q == WAIT
  );

endmodule
